// File: rtl/m68k_target_regs.sv
// 68000-bus register-bank target: 16-word window with ID, STAT, CTRL, SCRATCH and byte-laned RAM.
// Optional macro M68K_TARGET_BERR_EN turns hole accesses and RO writes into bus errors.
`timescale 1ns/1ps

module m68k_target_regs #(
    parameter logic [22:0] BASE_ADDR   = 23'h7F0000,
    parameter int unsigned WAIT_STATES = 2,
    parameter logic [15:0] ID_VALUE    = 16'h5053
) (
    input  logic        M68K_CLK,
    input  logic        M68K_RESET_n,
    input  logic [22:0] M68K_A,
    input  logic [2:0]  M68K_FC,
    input  logic        M68K_AS_n,
    input  logic        M68K_UDS_n,
    input  logic        M68K_LDS_n,
    input  logic        M68K_RW,
    input  logic [15:0] D_IN,
    output logic [15:0] D_OUT,
    output logic        D_OE,
    output logic        M68K_DTACK_n,
    output logic        M68K_BERR_n,
    input  logic [15:0] STAT,
    output logic [15:0] CTRL
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2
    } state_t;

    localparam logic [3:0] WAIT_CNT = 4'(WAIT_STATES);

    // Input capture stage
    logic [22:0] a_cap_reg;
    logic [2:0]  fc_cap_reg;
    logic        as_n_cap_reg;
    logic        uds_n_cap_reg;
    logic        lds_n_cap_reg;
    logic        rw_cap_reg;
    logic [15:0] d_cap_reg;

    // Cycle context and FSM
    state_t      state_reg;
    logic [3:0]  cnt_reg;
    logic [3:0]  idx_reg;
    logic        rw_reg;
    logic        uds_n_reg;
    logic        lds_n_reg;

    // Register file and outputs
    logic [15:0] ctrl_reg;
    logic [15:0] scratch_reg;
    logic [15:0] d_out_reg;
    logic        d_oe_reg;
    logic        dtack_n_reg;

    logic        select_hit;
    logic        commit;
    logic        access_err;
    logic        ram_we;
    logic [1:0]  lane_en;
    logic [15:0] ram_rd;
    logic [15:0] read_word;

    always_ff @(posedge M68K_CLK or negedge M68K_RESET_n) begin
        if (!M68K_RESET_n) begin
            a_cap_reg     <= '0;
            fc_cap_reg    <= '0;
            as_n_cap_reg  <= 1'b1;
            uds_n_cap_reg <= 1'b1;
            lds_n_cap_reg <= 1'b1;
            rw_cap_reg    <= 1'b1;
            d_cap_reg     <= '0;
        end else begin
            a_cap_reg     <= M68K_A;
            fc_cap_reg    <= M68K_FC;
            as_n_cap_reg  <= M68K_AS_n;
            uds_n_cap_reg <= M68K_UDS_n;
            lds_n_cap_reg <= M68K_LDS_n;
            rw_cap_reg    <= M68K_RW;
            d_cap_reg     <= D_IN;
        end
    end

    // CPU-space cycles (interrupt acknowledge etc.) must never hit the bank
    assign select_hit = !as_n_cap_reg
                      && (!uds_n_cap_reg || !lds_n_cap_reg)
                      && (fc_cap_reg != 3'd7)
                      && (a_cap_reg[22:4] == BASE_ADDR[22:4]);

    assign commit  = (state_reg == ST_WAIT) && !as_n_cap_reg && (cnt_reg == 4'd0);
    assign lane_en = {!uds_n_reg, !lds_n_reg};
    assign ram_we  = commit && !rw_reg && idx_reg[3];

`ifdef M68K_TARGET_BERR_EN
    logic berr_n_reg;

    assign access_err = (idx_reg[3:2] == 2'b01) || (!rw_reg && (idx_reg[3:1] == 3'b000));

    always_ff @(posedge M68K_CLK or negedge M68K_RESET_n) begin
        if (!M68K_RESET_n) begin
            berr_n_reg <= 1'b1;
        end else if (commit) begin
            berr_n_reg <= !access_err;
        end else if ((state_reg == ST_ACK) && as_n_cap_reg) begin
            berr_n_reg <= 1'b1;
        end
    end

    assign M68K_BERR_n = berr_n_reg;
`else
    assign access_err  = 1'b0;
    assign M68K_BERR_n = 1'b1;
`endif

    function automatic logic [15:0] lane_merge(input logic [15:0] old_word,
                                               input logic [15:0] wr_word,
                                               input logic [1:0]  en);
        logic [15:0] merged;
        merged = old_word;
        if (en[1]) merged[15:8] = wr_word[15:8];
        if (en[0]) merged[7:0]  = wr_word[7:0];
        return merged;
    endfunction

    // RAM is kept as two byte-wide arrays so each lane has its own write enable
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_lane
            logic [7:0] ram_lane [0:7];

            always_ff @(posedge M68K_CLK) begin
                if (ram_we && lane_en[gi]) begin
                    ram_lane[idx_reg[2:0]] <= d_cap_reg[8*gi +: 8];
                end
            end

            assign ram_rd[8*gi +: 8] = ram_lane[idx_reg[2:0]];
        end
    endgenerate

    always_comb begin
        read_word = 16'h0000;
        case (idx_reg)
            4'd0:    read_word = ID_VALUE;
            4'd1:    read_word = STAT;
            4'd2:    read_word = ctrl_reg;
            4'd3:    read_word = scratch_reg;
            default: if (idx_reg[3]) read_word = ram_rd;
        endcase
    end

    always_ff @(posedge M68K_CLK or negedge M68K_RESET_n) begin
        if (!M68K_RESET_n) begin
            state_reg   <= ST_IDLE;
            cnt_reg     <= '0;
            idx_reg     <= '0;
            rw_reg      <= 1'b1;
            uds_n_reg   <= 1'b1;
            lds_n_reg   <= 1'b1;
            ctrl_reg    <= '0;
            scratch_reg <= '0;
            d_out_reg   <= '0;
            d_oe_reg    <= 1'b0;
            dtack_n_reg <= 1'b1;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (select_hit) begin
                        idx_reg   <= a_cap_reg[3:0];
                        rw_reg    <= rw_cap_reg;
                        uds_n_reg <= uds_n_cap_reg;
                        lds_n_reg <= lds_n_cap_reg;
                        cnt_reg   <= WAIT_CNT;
                        state_reg <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (as_n_cap_reg) begin
                        state_reg <= ST_IDLE;
                    end else if (cnt_reg == 4'd0) begin
                        state_reg   <= ST_ACK;
                        dtack_n_reg <= access_err;
                        d_oe_reg    <= rw_reg && !access_err;
                        if (rw_reg) begin
                            d_out_reg <= read_word;
                        end else begin
                            if (idx_reg == 4'd2) ctrl_reg    <= lane_merge(ctrl_reg, d_cap_reg, lane_en);
                            if (idx_reg == 4'd3) scratch_reg <= lane_merge(scratch_reg, d_cap_reg, lane_en);
                        end
                    end else begin
                        cnt_reg <= cnt_reg - 4'd1;
                    end
                end
                ST_ACK: begin
                    if (as_n_cap_reg) begin
                        state_reg   <= ST_IDLE;
                        dtack_n_reg <= 1'b1;
                        d_oe_reg    <= 1'b0;
                    end
                end
                default: begin
                    state_reg   <= ST_IDLE;
                    dtack_n_reg <= 1'b1;
                    d_oe_reg    <= 1'b0;
                end
            endcase
        end
    end

    assign D_OUT        = d_out_reg;
    assign D_OE         = d_oe_reg;
    assign M68K_DTACK_n = dtack_n_reg;
    assign CTRL         = ctrl_reg;

endmodule

// File: tb/tb_m68k_target_regs.sv
// Scoreboard bench for m68k_target_regs: random bus cycles checked against a word-level register model.
`timescale 1ns/1ps

module tb_m68k_target_regs;

    localparam logic [22:0] BASE = 23'h7F0000;
    localparam int          WS   = 2;
    localparam logic [15:0] IDV  = 16'h5053;
`ifdef M68K_TARGET_BERR_EN
    localparam bit BERR_EN = 1'b1;
`else
    localparam bit BERR_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [22:0] addr = '0;
    logic [2:0]  fc = 3'd5;
    logic        as_n = 1'b1;
    logic        uds_n = 1'b1;
    logic        lds_n = 1'b1;
    logic        rw = 1'b1;
    logic [15:0] d_in = '0;
    logic [15:0] d_out;
    logic        d_oe;
    logic        dtack_n;
    logic        berr_n;
    logic [15:0] stat = 16'h0000;
    logic [15:0] ctrl;

    m68k_target_regs #(.BASE_ADDR(BASE), .WAIT_STATES(WS), .ID_VALUE(IDV)) dut (
        .M68K_CLK(clk), .M68K_RESET_n(rst_n), .M68K_A(addr), .M68K_FC(fc),
        .M68K_AS_n(as_n), .M68K_UDS_n(uds_n), .M68K_LDS_n(lds_n), .M68K_RW(rw),
        .D_IN(d_in), .D_OUT(d_out), .D_OE(d_oe), .M68K_DTACK_n(dtack_n),
        .M68K_BERR_n(berr_n), .STAT(stat), .CTRL(ctrl)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          berr;
        bit          rd;
        logic [15:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;

    // Reference model: plain word storage
    logic [15:0] m_ctrl = 16'h0000;
    logic [15:0] m_scratch = 16'h0000;
    logic [15:0] m_ram [8];

    function automatic void model_access(input int idx, input bit is_rd, input bit uds,
                                         input bit lds, input logic [15:0] wd, output exp_t e);
        logic [15:0] mask;
        mask   = {uds ? 8'hFF : 8'h00, lds ? 8'hFF : 8'h00};
        e.berr = BERR_EN && ((idx >= 4 && idx <= 7) || (!is_rd && idx < 2));
        e.rd   = is_rd;
        e.data = 16'h0000;
        if (is_rd) begin
            if (idx == 0)      e.data = IDV;
            else if (idx == 1) e.data = stat;
            else if (idx == 2) e.data = m_ctrl;
            else if (idx == 3) e.data = m_scratch;
            else if (idx >= 8) e.data = m_ram[idx-8];
        end else begin
            if (idx == 2)      m_ctrl    = (m_ctrl & ~mask) | (wd & mask);
            else if (idx == 3) m_scratch = (m_scratch & ~mask) | (wd & mask);
            else if (idx >= 8) m_ram[idx-8] = (m_ram[idx-8] & ~mask) | (wd & mask);
        end
    endfunction

    // Monitor: pops one expectation on every new acknowledge
    bit prev_dtack_n = 1'b1;
    bit prev_berr_n = 1'b1;
    always @(negedge clk) begin
        exp_t e;
        bit   ok;
        if (rst_n && ((!dtack_n && prev_dtack_n) || (!berr_n && prev_berr_n))) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL scoreboard_unexpected: ack with empty queue dtack_n=%b berr_n=%b", dtack_n, berr_n);
            end else begin
                e  = exp_q.pop_front();
                ok = (e.berr ? (!berr_n && dtack_n) : (!dtack_n && berr_n))
                   && (d_oe == (e.rd && !e.berr))
                   && (!(e.rd && !e.berr) || d_out == e.data);
                if (!ok) begin
                    bad++;
                    $display("FAIL scoreboard: got dtack_n=%b berr_n=%b d_oe=%b d_out=%h, required berr=%b rd=%b data=%h",
                             dtack_n, berr_n, d_oe, d_out, e.berr, e.rd, e.data);
                end else begin
                    $display("txn ok: rd=%b berr=%b data=%h", e.rd, e.berr, d_out);
                end
            end
        end
        prev_dtack_n = dtack_n;
        prev_berr_n  = berr_n;
    end

    task automatic bus_cycle(input logic [2:0] f, input logic [22:0] a, input bit is_rd,
                             input bit uds, input bit lds, input logic [15:0] wd,
                             input bit expect_resp, output logic [15:0] rdata);
        exp_t e;
        int   cycles;
        bit   seen;
        @(posedge clk); #1;
        addr = a; fc = f; rw = is_rd; d_in = wd; as_n = 1'b0;
        if (!is_rd) begin
            @(posedge clk); #1;
        end
        uds_n = !uds; lds_n = !lds;
        if (expect_resp) begin
            model_access(int'(a[3:0]), is_rd, uds, lds, wd, e);
            exp_q.push_back(e);
        end
        seen = 1'b0; cycles = 0;
        while (!seen && cycles < (expect_resp ? 40 : WS + 8)) begin
            @(posedge clk); cycles++;
            @(negedge clk);
            seen = !dtack_n || !berr_n || (!expect_resp && d_oe);
        end
        rdata = d_out;
        total++;
        if (expect_resp) begin
            if (!seen || cycles != WS + 3) begin
                bad++;
                $display("FAIL ack_latency: got %0d cycles (seen=%0b), required %0d", cycles, seen, WS + 3);
                if (!seen) void'(exp_q.pop_back());
            end
        end else if (seen) begin
            bad++;
            $display("FAIL no_response: got dtack_n=%b berr_n=%b d_oe=%b, required 1/1/0", dtack_n, berr_n, d_oe);
        end
        @(posedge clk); #1;
        as_n = 1'b1; uds_n = 1'b1; lds_n = 1'b1; rw = 1'b1;
        @(posedge clk); @(negedge clk);
        if (expect_resp && seen) begin
            total++;
            if (dtack_n && berr_n) begin
                bad++;
                $display("FAIL release_early: ack dropped one clock too soon");
            end
        end
        @(posedge clk); @(negedge clk);
        total++;
        if (!dtack_n || !berr_n || d_oe) begin
            bad++;
            $display("FAIL release: got dtack_n=%b berr_n=%b d_oe=%b, required 1/1/0", dtack_n, berr_n, d_oe);
        end
        total++;
        if (ctrl !== m_ctrl) begin
            bad++;
            $display("FAIL ctrl_port: got %h, required %h", ctrl, m_ctrl);
        end
    endtask

    task automatic check_val(input string name, input logic [15:0] got, input logic [15:0] req);
        total++;
        if (got !== req) begin
            bad++;
            $display("FAIL %s: got %h, required %h", name, got, req);
        end else begin
            $display("check ok: %s = %h", name, got);
        end
    endtask

    initial begin
        logic [15:0] rd;
        exp_t        e;
        int          cycles;
        bit          seen;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (d_out !== 16'h0 || d_oe !== 1'b0 || dtack_n !== 1'b1 || berr_n !== 1'b1 || ctrl !== 16'h0) begin
            bad++;
            $display("FAIL reset_state: got d_out=%h d_oe=%b dtack_n=%b berr_n=%b ctrl=%h", d_out, d_oe, dtack_n, berr_n, ctrl);
        end
        rst_n = 1'b1;

        // ID read with latency check
        bus_cycle(3'd5, BASE | 23'd0, 1'b1, 1'b1, 1'b1, 16'h0, 1'b1, rd);
        check_val("id_read", rd, 16'h5053);

        // Aborted CTRL write: AS drops while still waiting
        @(posedge clk); #1;
        addr = BASE | 23'd2; fc = 3'd5; rw = 1'b0; d_in = 16'hFFFF; as_n = 1'b0;
        @(posedge clk); #1;
        uds_n = 1'b0; lds_n = 1'b0;
        @(posedge clk); #1;
        as_n = 1'b1; uds_n = 1'b1; lds_n = 1'b1; rw = 1'b1;
        seen = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (!dtack_n || !berr_n || d_oe) seen = 1'b1;
        end
        total++;
        if (seen) begin
            bad++;
            $display("FAIL abort_no_ack: an acknowledge appeared on an aborted cycle");
        end
        check_val("abort_ctrl", ctrl, 16'h0000);

        // RAM prefill through the normal write path
        for (int i = 0; i < 8; i++)
            bus_cycle(3'd1, BASE | 23'(8 + i), 1'b0, 1'b1, 1'b1, 16'($urandom), 1'b1, rd);

        // Byte-lane merges on RAM[3]
        bus_cycle(3'd5, BASE | 23'd11, 1'b0, 1'b1, 1'b1, 16'h1111, 1'b1, rd);
        bus_cycle(3'd5, BASE | 23'd11, 1'b0, 1'b1, 1'b0, 16'hA5C3, 1'b1, rd);
        bus_cycle(3'd5, BASE | 23'd11, 1'b1, 1'b1, 1'b1, 16'h0, 1'b1, rd);
        check_val("ram_uds_merge", rd, 16'hA511);
        bus_cycle(3'd5, BASE | 23'd11, 1'b0, 1'b1, 1'b1, 16'h1111, 1'b1, rd);
        bus_cycle(3'd5, BASE | 23'd11, 1'b0, 1'b0, 1'b1, 16'hA5C3, 1'b1, rd);
        bus_cycle(3'd5, BASE | 23'd11, 1'b1, 1'b1, 1'b1, 16'h0, 1'b1, rd);
        check_val("ram_lds_merge", rd, 16'h11C3);

        // Undecoded cycles: CPU space and outside the window
        bus_cycle(3'd7, BASE | 23'd2, 1'b0, 1'b1, 1'b1, 16'hBEEF, 1'b0, rd);
        bus_cycle(3'd7, BASE | 23'd0, 1'b1, 1'b1, 1'b1, 16'h0, 1'b0, rd);
        bus_cycle(3'd5, (BASE ^ 23'h000100) | 23'd3, 1'b0, 1'b1, 1'b1, 16'hBEEF, 1'b0, rd);
        bus_cycle(3'd5, BASE | 23'd2, 1'b1, 1'b1, 1'b1, 16'h0, 1'b1, rd);
        check_val("ctrl_untouched", rd, 16'h0000);
        bus_cycle(3'd5, BASE | 23'd3, 1'b1, 1'b1, 1'b1, 16'h0, 1'b1, rd);
        check_val("scratch_untouched", rd, 16'h0000);

        // Write to STAT register, then read live status back
        stat = 16'h3C5A;
        bus_cycle(3'd5, BASE | 23'd1, 1'b0, 1'b1, 1'b1, 16'hFFFF, 1'b1, rd);
        bus_cycle(3'd5, BASE | 23'd1, 1'b1, 1'b1, 1'b1, 16'h0, 1'b1, rd);
        check_val("stat_read", rd, 16'h3C5A);

        // Randomized traffic
        for (int i = 0; i < 80; i++) begin
            int          r;
            int          lanes;
            logic [22:0] a;
            stat  = 16'($urandom);
            r     = $urandom_range(0, 9);
            lanes = $urandom_range(1, 3);
            a     = BASE | 23'($urandom_range(0, 15));
            if (r == 0)
                bus_cycle(3'd7, a, 1'($urandom_range(0, 1)), lanes[1], lanes[0], 16'($urandom), 1'b0, rd);
            else if (r == 1)
                bus_cycle(3'd5, a ^ (23'd1 << $urandom_range(4, 22)), 1'($urandom_range(0, 1)),
                          lanes[1], lanes[0], 16'($urandom), 1'b0, rd);
            else
                bus_cycle(3'($urandom_range(0, 6)), a, 1'($urandom_range(0, 1)), lanes[1], lanes[0],
                          16'($urandom), 1'b1, rd);
        end

        // Reset asserted during the ACK phase of a read
        bus_cycle(3'd5, BASE | 23'd2, 1'b0, 1'b1, 1'b1, 16'h1234, 1'b1, rd);
        @(posedge clk); #1;
        addr = BASE | 23'd2; fc = 3'd5; rw = 1'b1; as_n = 1'b0; uds_n = 1'b0; lds_n = 1'b0;
        model_access(2, 1'b1, 1'b1, 1'b1, 16'h0, e);
        exp_q.push_back(e);
        seen = 1'b0; cycles = 0;
        while (!seen && cycles < 40) begin
            @(posedge clk); cycles++;
            @(negedge clk);
            seen = !dtack_n;
        end
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL reset_ack_timeout: no acknowledge within %0d cycles", cycles);
            void'(exp_q.pop_back());
        end
        #2 rst_n = 1'b0;
        m_ctrl = 16'h0000; m_scratch = 16'h0000;
        #1;
        total++;
        if (dtack_n !== 1'b1 || d_oe !== 1'b0 || ctrl !== 16'h0) begin
            bad++;
            $display("FAIL reset_release: got dtack_n=%b d_oe=%b ctrl=%h, required 1/0/0000", dtack_n, d_oe, ctrl);
        end
        as_n = 1'b1; uds_n = 1'b1; lds_n = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        bus_cycle(3'd5, BASE | 23'd2, 1'b1, 1'b1, 1'b1, 16'h0, 1'b1, rd);
        check_val("ctrl_after_reset", rd, 16'h0000);

        repeat (4) @(posedge clk);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_leftover: got %0d pending, required 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/m68k_target_regs.md
# m68k_target_regs

Register-bank responder on the 68000 bus, the target-side counterpart of the PiStorm bus initiator. It decodes a 16-word window, answers CPU/initiator cycles with DTACK after a programmable number of wait states, and serves ID, status, control, scratch and 8 words of byte-laned RAM. It sits on the Amiga-side bus and lets the initiator's full S0–S7 sequence, including DTACK wait states, be exercised in-system against a known target.

## Interface
- BASE_ADDR, 23'h7F0000, word address A[23:1]; window match uses bits [23:5].
- WAIT_STATES, 2, clocks inserted before DTACK, range 0–15.
- ID_VALUE, 16'h5053, value returned by register 0.
- M68K_CLK  in  1  bus clock; everything is on its rising edge.
- M68K_RESET_n  in  1  asynchronous, active-low reset.
- M68K_A  in  23  address A[23:1].
- M68K_FC  in  3  function code; FC = 3'd7 (CPU space) is never decoded.
- M68K_AS_n, M68K_UDS_n, M68K_LDS_n  in  1 each  strobes.
- M68K_RW  in  1  1 = read.
- D_IN  in  16  data from bus.
- D_OUT  out  16  read data.
- D_OE  out  1  drive D_OUT onto bus.
- M68K_DTACK_n  out  1  0 = acknowledge.
- M68K_BERR_n  out  1  0 = bus error.
- STAT  in  16  live status, read via register 1.
- CTRL  out  16  control register contents.

## Operation
- All bus inputs are captured into one register stage every clock; the FSM acts only on the captured values.
- Register map by A[4:1]: 0 ID (RO), 1 STAT (RO), 2 CTRL (RW), 3 SCRATCH (RW), 4–7 hole, 8–15 RAM[0..7] (RW).
- Select: AS low, UDS or LDS low, FC ≠ 7, A[23:5] == BASE_ADDR[23:5].
- FSM states:
  - IDLE: on select, latch A[4:1], RW, UDS, LDS; load cnt = WAIT_STATES; go to WAIT.
  - WAIT: if captured AS is high, abort to IDLE with no write. Else if cnt == 0, go to ACK. Else cnt−1.
  - ACK: hold DTACK_n = 0 (or BERR_n = 0), and D_OE = 1 on reads; go to IDLE on captured AS high.
- Write commit happens on the WAIT→ACK edge, using the captured D_IN. UDS selects [15:8] and LDS selects [7:0]. A disabled lane is left unchanged.
- Read data is latched into D_OUT on the WAIT→ACK edge as a full word, regardless of lanes. Hole reads return 16'h0000.
- Writes to RO registers or to holes are dropped.
- A new select is not accepted until after a return to IDLE. A back-to-back AS is recognised no earlier than one clock after ACK exits.

## Timing
- Reset values: D_OUT = 0, D_OE = 0, DTACK_n = 1, BERR_n = 1, CTRL = 0, SCRATCH = 0. RAM is not reset. State = IDLE.
- Reset mid-cycle: all outputs are released immediately (asynchronously). A pending write is not committed.
- If select is captured at edge k: WAIT is entered at k+1, and DTACK_n/D_OE assert after edge k+2+WAIT_STATES.
- Write cycles: the 68000 drops DS one clock after AS, so select, and therefore latency, starts from the DS capture.
- If AS high is captured at edge m: DTACK_n, BERR_n and D_OE all deassert after edge m+1.
- CTRL updates on the commit edge. STAT is sampled on the commit edge.
- A DS change during WAIT or ACK is ignored; the lanes latched in IDLE are used.

## Configuration
- M68K_TARGET_BERR_EN defined: accesses to holes (4–7) and writes to RO registers (0, 1) assert BERR_n = 0 in ACK instead of DTACK_n. D_OE stays 0 for these accesses.
- M68K_TARGET_BERR_EN undefined: BERR_n is tied to 1. Such accesses get a normal DTACK; hole reads return 0 and bad writes are dropped.

## Test plan
- Reset, then WAIT_STATES = 2: read reg 0 with select captured at edge 10 → DTACK_n = 0 and D_OUT = 16'h5053 after edge 14. Release after AS high is captured +1.
- Write 16'hA5C3 to RAM[3] with UDS only, after pre-filling 16'h1111 → a read returns 16'hA511. Repeat with LDS only → 16'hA5C3-low merge gives 16'h11C3 on a fresh 16'h1111.
- FC = 7 or an address outside the window → DTACK_n and D_OE remain 1 for the whole cycle, and no register changes.
- AS deasserted during WAIT with WAIT_STATES = 8 → return to IDLE with no DTACK, and the CTRL write of 16'hFFFF is not applied (CTRL stays 0).
- With M68K_TARGET_BERR_EN: write to reg 1 → BERR_n = 0, DTACK_n = 1. Without it: DTACK_n = 0 and STAT readback is unchanged.
- Assert M68K_RESET_n = 0 during ACK of a read → D_OE and DTACK_n are released the same cycle, and CTRL reads 0 afterwards.
